// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Definitions shared across the integer ALU datapath.
//   OP_ADD / OP_SUB : encoding of the add/subtract select input
//   state_t         : control states of the multi-cycle add/subtract unit
//   FLAG_*          : bit positions of the condition flags inside a flag vector
//   FLAGS_RESET     : flag vector value after reset (only zero set, because the
//                     cleared result is 0)
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_C    = 0;   // carry (add) / borrow (subtract)
    localparam int FLAG_V    = 1;   // signed overflow
    localparam int FLAG_Z    = 2;   // result is zero
    localparam int FLAG_N    = 3;   // result MSB
    localparam int NUM_FLAGS = 4;

    localparam logic [NUM_FLAGS-1:0] FLAGS_RESET = 4'b0100;

endpackage : alu_pkg

// File: rtl/addsub_chunk.sv
// ----------------------------------------------------------------------------
// addsub_chunk
// Combinational CHUNK-bit ripple adder used as the per-cycle slice of the
// serial add/subtract unit. Subtraction is handled by the caller (inverted y
// and inverted carry in), so this block only ever adds.
//   x, y  : slice operands
//   cin   : carry into bit 0
//   sum   : x + y + cin (low CHUNK bits)
//   cout  : carry out of the slice MSB
//   c_msb : carry into the slice MSB; XOR with cout gives signed overflow
//           when this is the top slice of the word
// ----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[CHUNK] leaves the slice.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule : addsub_chunk

// File: rtl/addsub_serial.sv
// ----------------------------------------------------------------------------
// addsub_serial
// Multi-cycle WIDTH-bit add/subtract unit built around a CHUNK-bit adder.
// One slice is processed per clock, least significant slice first, so an
// operation takes N = WIDTH/CHUNK cycles after the accepting edge.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; aborts any operation in flight
//   start      : request, sampled only in IDLE or DONE
//   op         : OP_ADD (0) or OP_SUB (1)
//   a, b       : operands (a - b for subtract)
//   carry_in   : carry in (add) / borrow in (subtract)
//   busy       : operation in progress
//   done       : one-cycle pulse when the result/flag outputs update
//   difference : result (name shared with the older combinational block)
//   carry_out  : carry out (add) / borrow out (subtract)
//   overflow   : signed two's-complement overflow
//   zero       : difference == 0
//   negative   : difference[WIDTH-1]
//
// Subtraction is done as a + ~b + ~carry_in, with the final carry inverted to
// give an unsigned borrow. The partial sum lives in its own register so the
// visible outputs only move on completion.
// ----------------------------------------------------------------------------
module addsub_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    // Partial-sum register holds the slices already produced; with a single
    // slice there is nothing to hold, so it is kept one bit wide and unused.
    localparam int PART_W = (N > 1) ? (WIDTH - CHUNK) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("addsub_serial: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   load;        // latch operands, restart slice counter
    logic   step;        // process one slice
    logic   last_chunk;  // the slice being processed is the top one

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     a_sh_reg;     // operand a, shifted right per slice
    logic [WIDTH-1:0]     b_sh_reg;     // operand b (pre-inverted for subtract)
    logic                 carry_reg;    // carry chained between slices
    logic                 op_reg;       // latched operation
    logic [IDX_W-1:0]     idx_reg;      // slice index
    logic [PART_W-1:0]    part_reg;     // slices produced so far, top-aligned
    logic [PART_W-1:0]    part_next;

    logic [WIDTH-1:0]     diff_reg;
    logic [NUM_FLAGS-1:0] flags_reg;
    logic [NUM_FLAGS-1:0] flags_final;

    // ------------------------------------------------------------------
    // Slice adder
    // ------------------------------------------------------------------
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    logic [WIDTH-1:0] sum_full;     // full word as it stands after this slice

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (a_sh_reg[CHUNK-1:0]),
        .y     (b_sh_reg[CHUNK-1:0]),
        .cin   (carry_reg),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    // New slices enter at the top and older ones move down, so after the
    // last slice the word is in its natural bit order.
    generate
        if (N == 1) begin : g_single
            assign sum_full  = chunk_sum;
            assign part_next = 1'b0;
        end else begin : g_multi
            assign sum_full  = {chunk_sum, part_reg};
            assign part_next = sum_full[WIDTH-1:CHUNK];
        end
    endgenerate

    assign last_chunk = (idx_reg == LAST_IDX);

    // Flags are only meaningful on the top slice, where chunk_cout and
    // chunk_c_msb are the word's carry out of / into the MSB.
    always_comb begin
        flags_final         = '0;
        flags_final[FLAG_C] = (op_reg == OP_SUB) ? ~chunk_cout : chunk_cout;
        flags_final[FLAG_V] = chunk_c_msb ^ chunk_cout;
        flags_final[FLAG_Z] = ~|sum_full;
        flags_final[FLAG_N] = sum_full[WIDTH-1];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored here; it is not queued.
                step = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Accepting here gives back-to-back operations every N+1 cycles.
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            carry_reg <= 1'b0;
            op_reg    <= OP_ADD;
            idx_reg   <= '0;
            part_reg  <= '0;
            diff_reg  <= '0;
            flags_reg <= FLAGS_RESET;
        end else if (load) begin
            a_sh_reg  <= a;
            b_sh_reg  <= (op == OP_SUB) ? ~b : b;
            carry_reg <= (op == OP_SUB) ? ~carry_in : carry_in;
            op_reg    <= op;
            idx_reg   <= '0;
        end else if (step) begin
            a_sh_reg  <= a_sh_reg >> CHUNK;
            b_sh_reg  <= b_sh_reg >> CHUNK;
            carry_reg <= chunk_cout;
            part_reg  <= part_next;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (last_chunk) begin
                diff_reg  <= sum_full;
                flags_reg <= flags_final;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (state_reg == RUN);
    assign done       = (state_reg == DONE);
    assign difference = diff_reg;
    assign carry_out  = flags_reg[FLAG_C];
    assign overflow   = flags_reg[FLAG_V];
    assign zero       = flags_reg[FLAG_Z];
    assign negative   = flags_reg[FLAG_N];

endmodule : addsub_serial

// File: tb/tb_addsub_serial.sv
// ----------------------------------------------------------------------------
// tb_addsub_serial
// Directed vectors with hand-computed results for addsub_serial (WIDTH=16,
// CHUNK=4). The stimulus side pushes the expected result/flags and the
// accepting cycle into a scoreboard queue; an independent monitor pops an
// entry on every done pulse and compares result, flags and latency.
// Result vector layout: {difference, carry_out, overflow, zero, negative}.
// ----------------------------------------------------------------------------
module tb_addsub_serial;
    import alu_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 4;     // WIDTH / CHUNK

    localparam logic [19:0] RST_VEC = {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op = OP_ADD;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          carry_in = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  difference;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic          negative;

    addsub_serial #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .carry_in   (carry_in),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero),
        .negative   (negative)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [19:0] res;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] hold_vec = RST_VEC;   // what the outputs must show while busy

    wire [19:0] dut_vec = {difference, carry_out, overflow, zero, negative};

    function automatic logic [19:0] ev(input logic [15:0] d, input logic c,
                                       input logic v, input logic z, input logic n);
        return {d, c, v, z, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: every done pulse consumes one scoreboard entry.
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual done=1 with empty scoreboard, required no done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                $display("txn %s: diff=%h c=%b v=%b z=%b n=%b latency=%0d",
                         e.name, difference, carry_out, overflow, zero, negative, cyc - e.acc);
                chk({e.name, "_result"}, 32'(dut_vec), 32'(e.res));
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    task automatic push_exp(input string name, input logic [19:0] res);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.acc  = cyc;
        sb.push_back(e);
    endtask

    // One isolated operation; optionally re-pulses start during RUN.
    task automatic run_op(input string name, input logic o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic ci,
                          input logic [19:0] exp_res, input bit repulse);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; carry_in = ci;
        @(posedge clk); #1;
        push_exp(name, exp_res);
        // Operands may change freely after the accepting edge.
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = ~o; carry_in = ~ci;
        chk({name, "_busy_on_accept"}, 32'(busy), 32'(1));
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk({name, "_busy_hold"}, 32'({busy, done, dut_vec}), 32'({1'b1, 1'b0, hold_vec}));
            if (repulse && k == 0) begin
                start = 1'b1; op = OP_ADD; a = 16'hFFFF; b = 16'h0001;
            end
            if (repulse && k == 1) start = 1'b0;
        end
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'({busy, done}), 32'(2'b01));
        hold_vec = exp_res;
        @(negedge clk);
        chk({name, "_done_drop"}, 32'({busy, done}), 32'(2'b00));
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #50000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'({busy, done, dut_vec}), 32'({2'b00, RST_VEC}));
        reset = 1'b0;

        run_op("sub_4_2",     OP_SUB, 16'h0004, 16'h0002, 1'b0, ev(16'h0002, 0, 0, 0, 0), 1'b0);
        run_op("sub_0_1",     OP_SUB, 16'h0000, 16'h0001, 1'b0, ev(16'hFFFF, 1, 0, 0, 1), 1'b0);
        run_op("sub_1_1",     OP_SUB, 16'h0001, 16'h0001, 1'b0, ev(16'h0000, 0, 0, 1, 0), 1'b0);
        run_op("add_7fff_1",  OP_ADD, 16'h7FFF, 16'h0001, 1'b0, ev(16'h8000, 0, 1, 0, 1), 1'b0);
        run_op("sub_8000_1",  OP_SUB, 16'h8000, 16'h0001, 1'b0, ev(16'h7FFF, 0, 1, 0, 0), 1'b0);
        run_op("add_ffff_c",  OP_ADD, 16'hFFFF, 16'h0000, 1'b1, ev(16'h0000, 1, 0, 1, 0), 1'b0);
        run_op("sub_5_5_b",   OP_SUB, 16'h0005, 16'h0005, 1'b1, ev(16'hFFFF, 1, 0, 0, 1), 1'b0);
        run_op("repulse_sub", OP_SUB, 16'h0100, 16'h0001, 1'b0, ev(16'h00FF, 0, 0, 0, 0), 1'b1);

        // Back-to-back: start held high, new operands after each accept.
        @(negedge clk);
        start = 1'b1; op = OP_SUB; a = 16'h1000; b = 16'h2000; carry_in = 1'b0;
        @(posedge clk); #1;
        push_exp("b2b_a", ev(16'hF000, 1, 0, 0, 1));
        op = OP_ADD; a = 16'h1234; b = 16'h4321; carry_in = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        push_exp("b2b_b", ev(16'h5555, 0, 0, 0, 0));
        chk("b2b_b_busy_on_accept", 32'(busy), 32'(1));
        op = OP_ADD; a = 16'h8000; b = 16'h8000; carry_in = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        push_exp("b2b_c", ev(16'h0000, 1, 1, 1, 0));
        chk("b2b_c_busy_on_accept", 32'(busy), 32'(1));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("b2b_drained", 32'(sb.size()), 32'(0));
        hold_vec = ev(16'h0000, 1, 1, 1, 0);
        @(negedge clk);

        // Reset asserted at E2 of an operation: aborted, no done.
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 16'h1111; b = 16'h2222; carry_in = 1'b0;
        @(posedge clk); #1;                 // E0
        start = 1'b0;
        chk("abort_busy_on_accept", 32'(busy), 32'(1));
        @(posedge clk);                     // E1
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;                 // E2 samples reset
        chk("abort_reset_values", 32'({busy, done, dut_vec}), 32'({2'b00, RST_VEC}));
        @(negedge clk);
        reset = 1'b0;
        hold_vec = RST_VEC;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({busy, done}), 32'(2'b00));
        end

        run_op("after_abort", OP_SUB, 16'h0010, 16'h0003, 1'b0, ev(16'h000D, 0, 0, 0, 0), 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_addsub_serial

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle add/subtract unit that is the sequential successor of the 4-bit `subtraction` block. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, under a start/busy/done handshake. It supports add and subtract (with carry/borrow in) and produces carry/borrow, signed-overflow, zero and negative flags. It sits in the integer ALU datapath wherever a narrow adder must serve wide operands.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; N = WIDTH/CHUNK cycles per operation.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- op  in  1  0 = add, 1 = subtract
- a  in  WIDTH  minuend / addend
- b  in  WIDTH  subtrahend / addend
- carry_in  in  1  add: carry in; subtract: borrow in
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when outputs update
- difference  out  WIDTH  result (name kept for compatibility with `subtraction`)
- carry_out  out  1  add: carry out; subtract: borrow out
- overflow  out  1  signed (two's-complement) overflow
- zero  out  1  difference == 0
- negative  out  1  difference[WIDTH-1]

## Operation
- Arithmetic semantics:
  - Add: {carry_out, difference} = a + b + carry_in.
  - Subtract: difference = a - b - carry_in mod 2^WIDTH; carry_out = 1 iff a < b + carry_in (unsigned borrow).
- Implementation of subtract: a + ~b + ~carry_in, with carry_out = NOT(final carry).
- Overflow:
  - Equals carry into MSB XOR carry out of MSB, taken from the last chunk.
  - Add: a and b have the same sign and the result sign differs.
  - Subtract: a and b have different signs and the result sign differs from a.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, op, carry_in (inverted b and carry for subtract), clears chunk index, goes to RUN.
  - RUN: one chunk per edge, LSB chunk first. A running carry register chains the chunks. Partial sums go to an internal register, not to the outputs. After chunk N-1, goes to DONE and loads difference and all flags.
  - DONE: done=1. start=1 here is accepted (back-to-back, same as IDLE), otherwise go to IDLE.
- start during RUN is ignored; it is not queued.
- Operand inputs may change freely after the accepting edge.
- Outputs hold their last values until the next completion. They do not change while busy.

## Timing
- Reset values: busy=0, done=0, difference=0, carry_out=0, overflow=0, zero=1, negative=0. State is IDLE, chunk index is 0.
- Let edge E0 sample start=1. busy=1 from E0 through EN.
- Chunks are processed at edges E1..EN.
- After EN: outputs are valid, done=1 and busy=0 for exactly one cycle.
- Latency from start to done is N cycles (4 at default parameters).
- Throughput is one operation per N+1 cycles; start held high continuously gives this rate.
- Reset asserted mid-operation:
  - Next edge forces reset values.
  - done is never pulsed for the aborted operation.
- Reset and start in the same cycle: reset wins.
- N=1 (CHUNK=WIDTH) is legal: done follows one cycle after the accepting edge.

## Structure
- Shared package `alu_pkg`:
  - OP_ADD/OP_SUB constants.
  - State enum (IDLE, RUN, DONE).
  - Flag index constants, shared with the rest of the ALU.
- Sub-module `addsub_chunk`: combinational CHUNK-bit adder.
  - Inputs: x, y, cin.
  - Outputs: sum, cout, c_msb (carry into the slice MSB, for overflow).
- Top level holds the FSM, chunk counter, operand shift registers and output/flag registers.
- Elaboration check: WIDTH % CHUNK == 0; otherwise fail.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Subtract, a=0x0004, b=0x0002, carry_in=0 -> difference=0x0002, carry_out=0, overflow=0, zero=0; done exactly 4 cycles after the accepting edge, busy high for those cycles.
- Subtract, a=0x0000, b=0x0001 -> difference=0xFFFF, carry_out=1, negative=1, overflow=0. Subtract, a=0x0001, b=0x0001 -> difference=0, zero=1.
- Add, a=0x7FFF, b=0x0001 -> difference=0x8000, overflow=1, negative=1, carry_out=0. Subtract, a=0x8000, b=0x0001 -> difference=0x7FFF, overflow=1, carry_out=0.
- Add, a=0xFFFF, b=0x0000, carry_in=1 -> difference=0x0000, carry_out=1, zero=1. Subtract, a=0x0005, b=0x0005, carry_in=1 -> difference=0xFFFF, carry_out=1.
- start re-pulsed with new operands during RUN -> ignored; first result delivered intact. start held high through DONE -> next operation accepted, done pulses every 5 cycles.
- Reset asserted at edge E2 of an operation -> next cycle busy=0, outputs at reset values, no done pulse; a subsequent start completes normally.
